score_hex_display: RTL and testbench
====================================

SCORE_HEX_DISPLAY -- requirements
Module: score_hex_display

Interface
REQ-001 Parameter FLASH_FRAMES, default 60, number of frames the level digit flashes after a level change.
REQ-002 Parameter BLINK_BIT, default 3, flash-counter bit that gates level-digit visibility.
REQ-003 clk  in  1  system clock.
REQ-004 resetN  in  1  asynchronous active-low reset.
REQ-005 startOfFrame  in  1  one-clock pulse per video frame (30Hz).
REQ-006 score  in  12  game score, 3 BCD digits: [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-007 level  in  4  current level, binary.
REQ-008 birdsLeft  in  4  birds remaining, binary.
REQ-009 currScreen  in  2  0 START, 1 PLAY, 2 OVER, 3 WIN.
REQ-010 newLevelPulse  in  1  one-clock pulse on level advance.
REQ-011 HEX0..HEX5  out  7 each  active-low segments, bit order gfedcba; HEX0 units, HEX1 tens, HEX2 hundreds, HEX3 birdsLeft, HEX4 level, HEX5 screen glyph.
REQ-012 dispScore  out  12  BCD score currently shown.
REQ-013 countingUp  out  1  high while dispScore is below the sampled score.

Function
REQ-014 FSM states REST_ST and COUNT_ST; all state changes occur only on clocks where startOfFrame=1.
REQ-015 On a startOfFrame clock the block samples score, level, birdsLeft and currScreen into frame registers; display content derives only from frame registers and dispScore.
REQ-016 On a startOfFrame clock: score == dispScore -> dispScore unchanged, next REST_ST; score > dispScore (unsigned 12-bit compare) -> dispScore <= BCD increment of dispScore, next COUNT_ST; score < dispScore -> dispScore <= score, next REST_ST.
REQ-017 BCD increment: units 9 wraps to 0 with carry into tens, tens 9 wraps to 0 with carry into hundreds, 999 wraps to 000.
REQ-018 countingUp is registered and equals (state == COUNT_ST).
REQ-019 newLevelPulse on any clock loads the flash counter with FLASH_FRAMES; otherwise a nonzero counter decrements by 1 on each startOfFrame; simultaneous pulse and startOfFrame -> load wins.
REQ-020 HEX4 blank while flash counter nonzero and counter[BLINK_BIT]=1; otherwise shows sampled level.
REQ-021 HEX4 blank when sampled currScreen = START regardless of level value.
REQ-022 Segment codes: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10, blank=7F, '-'=3F, P=0C, L=47, U=41 (hex).
REQ-023 Any digit source value above 9 (level, birdsLeft or a dispScore nibble) displays '-'.
REQ-024 Leading-zero blanking: HEX2 blank when hundreds=0; HEX1 blank when hundreds=0 and tens=0; HEX0 always shown.
REQ-025 HEX5: START '-', PLAY 'P', OVER 'L', WIN 'U'.
REQ-026 HEX3 shows sampled birdsLeft on PLAY, blank otherwise.
REQ-027 All HEX outputs registered; they reflect frame registers, dispScore and flash counter exactly one clock after those update.
REQ-028 Inputs changing between startOfFrame pulses have no effect on outputs except newLevelPulse.

Reset
REQ-029 resetN low asynchronously forces: state REST_ST, dispScore 000, countingUp 0, flash counter 0, frame score 000, level 0, birdsLeft 0, currScreen START.
REQ-030 During reset HEX0=40, HEX1..HEX4=7F, HEX5=3F.
REQ-031 Reset asserted mid-count aborts counting; after release dispScore restarts from 000 on next startOfFrame.

Verification
REQ-032 Reset, then score=048, currScreen=1, 48 startOfFrame pulses -> dispScore steps 001..048, countingUp high through 47th pulse, low after 48th, HEX1=19, HEX0=00, HEX2=7F.
REQ-033 dispScore=099, score=100, one startOfFrame -> dispScore=100, HEX2=79, HEX1=40, HEX0=40.
REQ-034 dispScore=144, score drops to 000 (new game), one startOfFrame -> dispScore=000, countingUp=0, HEX1/HEX2 blank.
REQ-035 newLevelPulse coincident with startOfFrame, level=2 -> counter=60; HEX4 alternates 24/7F every 8 frames; steady 24 after 60 frames.
REQ-036 currScreen 0,1,2,3 on successive frames -> HEX5 3F,0C,47,41; HEX4 blank on START even with level=9; birdsLeft=12 on PLAY -> HEX3=3F.
REQ-037 score/level changed mid-frame without startOfFrame -> no HEX output change until next startOfFrame plus one clock.

Source files
------------

// File: rtl/score_hex_display.sv
// score_hex_display: frame-synchronous score count-up and six-digit 7-segment status display
module score_hex_display #(
  parameter int FLASH_FRAMES = 60,
  parameter int BLINK_BIT    = 3
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [11:0] score,
  input  logic [3:0]  level,
  input  logic [3:0]  birdsLeft,
  input  logic [1:0]  currScreen,
  input  logic        newLevelPulse,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [11:0] dispScore,
  output logic        countingUp
);
  localparam int FW = ($clog2(FLASH_FRAMES + 1) > BLINK_BIT) ? $clog2(FLASH_FRAMES + 1) : BLINK_BIT + 1;
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] DASH  = 7'h3F;
  typedef enum logic {REST_ST, COUNT_ST} state_t;
  state_t          state_q, state_d;
  logic [11:0]     disp_q, disp_d, disp_inc;
  logic [FW-1:0]   flash_q, flash_d;
  logic [3:0]      level_q, birds_q;
  logic [1:0]      scr_q;
  logic [6:0]      hex0_d, hex1_d, hex2_d, hex3_d, hex4_d, hex5_d;
  logic            c_units, c_tens;
  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = DASH;
    endcase
  endfunction
  // BCD increment of the shown score with 999 wrapping to 000, plus next state and flash counter
  always_comb begin
    c_units  = disp_q[3:0] == 4'd9;
    c_tens   = c_units && disp_q[7:4] == 4'd9;
    disp_inc[3:0]  = c_units ? 4'd0 : disp_q[3:0] + 4'd1;
    disp_inc[7:4]  = c_units ? (disp_q[7:4] == 4'd9 ? 4'd0 : disp_q[7:4] + 4'd1) : disp_q[7:4];
    disp_inc[11:8] = c_tens ? (disp_q[11:8] == 4'd9 ? 4'd0 : disp_q[11:8] + 4'd1) : disp_q[11:8];
    disp_d   = !startOfFrame ? disp_q : (score > disp_q) ? disp_inc : score;
    state_d  = !startOfFrame ? state_q : (score > disp_q && disp_inc != score) ? COUNT_ST : REST_ST;
    flash_d  = newLevelPulse ? FW'(FLASH_FRAMES) : (startOfFrame && flash_q != '0) ? flash_q - 1'b1 : flash_q;
  end
  // Segment patterns derived only from frame registers, shown score and flash counter
  always_comb begin
    hex0_d = seg(disp_q[3:0]);
    hex1_d = (disp_q[11:8] == 4'd0 && disp_q[7:4] == 4'd0) ? BLANK : seg(disp_q[7:4]);
    hex2_d = (disp_q[11:8] == 4'd0) ? BLANK : seg(disp_q[11:8]);
    hex3_d = (scr_q == 2'd1) ? seg(birds_q) : BLANK;
    hex4_d = (scr_q == 2'd0 || (flash_q != '0 && flash_q[BLINK_BIT])) ? BLANK : seg(level_q);
    hex5_d = (scr_q == 2'd0) ? DASH : (scr_q == 2'd1) ? 7'h0C : (scr_q == 2'd2) ? 7'h47 : 7'h41;
  end
  // Frame sampling, count-up FSM, flash counter and registered display outputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= REST_ST;
      disp_q     <= '0;
      flash_q    <= '0;
      level_q    <= '0;
      birds_q    <= '0;
      scr_q      <= 2'd0;
      countingUp <= 1'b0;
      HEX0       <= 7'h40;
      HEX1       <= BLANK;
      HEX2       <= BLANK;
      HEX3       <= BLANK;
      HEX4       <= BLANK;
      HEX5       <= DASH;
    end else begin
      state_q    <= state_d;
      disp_q     <= disp_d;
      flash_q    <= flash_d;
      countingUp <= state_d == COUNT_ST;
      if (startOfFrame) begin
        level_q <= level;
        birds_q <= birdsLeft;
        scr_q   <= currScreen;
      end
      HEX0 <= hex0_d;
      HEX1 <= hex1_d;
      HEX2 <= hex2_d;
      HEX3 <= hex3_d;
      HEX4 <= hex4_d;
      HEX5 <= hex5_d;
    end
  end
  assign dispScore = disp_q;
endmodule

// File: tb/tb_score_hex_display.sv
// tb_score_hex_display: directed scoreboard bench for score_hex_display
module tb_score_hex_display;
  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic [11:0] score;
  logic [3:0]  level;
  logic [3:0]  birdsLeft;
  logic [1:0]  currScreen;
  logic        newLevelPulse;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [11:0] dispScore;
  logic        countingUp;
  typedef struct {
    string       tag;
    int          sel;
    logic [11:0] val;
  } exp_t;
  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  score_hex_display dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .score(score),
    .level(level), .birdsLeft(birdsLeft), .currScreen(currScreen),
    .newLevelPulse(newLevelPulse), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2),
    .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5), .dispScore(dispScore),
    .countingUp(countingUp)
  );
  always #5 clk = ~clk;
  function automatic logic [11:0] obs(input int sel);
    case (sel)
      0:       obs = {5'd0, HEX0};
      1:       obs = {5'd0, HEX1};
      2:       obs = {5'd0, HEX2};
      3:       obs = {5'd0, HEX3};
      4:       obs = {5'd0, HEX4};
      5:       obs = {5'd0, HEX5};
      6:       obs = dispScore;
      default: obs = {11'd0, countingUp};
    endcase
  endfunction
  function automatic logic [11:0] bcd(input int k);
    bcd = {4'(k / 100), 4'((k / 10) % 10), 4'(k % 10)};
  endfunction
  task automatic push(input string t, input int s, input logic [11:0] v);
    q.push_back('{t, s, v});
  endtask
  task automatic check();
    exp_t e;
    logic [11:0] o;
    while (q.size() > 0) begin
      e = q.pop_front();
      o = obs(e.sel);
      vectors++;
      assert (o === e.val) else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.val);
      end
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic frame();
    @(negedge clk) startOfFrame = 1'b1;
    @(negedge clk) startOfFrame = 1'b0;
  endtask
  initial begin
    int c;
    resetN = 1'b0; startOfFrame = 1'b0; score = '0; level = '0;
    birdsLeft = '0; currScreen = 2'd0; newLevelPulse = 1'b0;
    repeat (2) tick();
    push("rst_hex0", 0, 12'h40); push("rst_hex1", 1, 12'h7F); push("rst_hex2", 2, 12'h7F);
    push("rst_hex3", 3, 12'h7F); push("rst_hex4", 4, 12'h7F); push("rst_hex5", 5, 12'h3F);
    push("rst_ds", 6, 12'h000); push("rst_cu", 7, 12'h0);
    check();
    resetN = 1'b1; score = 12'h048; currScreen = 2'd1; level = 4'd1; birdsLeft = 4'd3;
    for (int k = 1; k <= 48; k++) begin
      frame();
      push("cnt_ds", 6, bcd(k));
      push("cnt_up", 7, 12'(k < 48));
      check();
    end
    tick();
    push("s48_hex0", 0, 12'h00); push("s48_hex1", 1, 12'h19); push("s48_hex2", 2, 12'h7F);
    push("s48_hex3", 3, 12'h30); push("s48_hex4", 4, 12'h79); push("s48_hex5", 5, 12'h0C);
    check();
    score = 12'h099;
    repeat (51) frame();
    tick();
    push("s99_ds", 6, 12'h099); push("s99_cu", 7, 12'h0);
    push("s99_hex0", 0, 12'h10); push("s99_hex1", 1, 12'h10); push("s99_hex2", 2, 12'h7F);
    check();
    score = 12'h100;
    frame(); tick();
    push("s100_ds", 6, 12'h100); push("s100_cu", 7, 12'h0);
    push("s100_hex2", 2, 12'h79); push("s100_hex1", 1, 12'h40); push("s100_hex0", 0, 12'h40);
    check();
    score = 12'h144;
    repeat (44) frame();
    tick();
    push("s144_ds", 6, 12'h144); push("s144_hex1", 1, 12'h19); push("s144_hex0", 0, 12'h19);
    check();
    score = 12'h000;
    frame(); tick();
    push("drop_ds", 6, 12'h000); push("drop_cu", 7, 12'h0);
    push("drop_hex1", 1, 12'h7F); push("drop_hex2", 2, 12'h7F); push("drop_hex0", 0, 12'h40);
    check();
    score = 12'h005; level = 4'd7;
    repeat (3) tick();
    push("mid_hex0", 0, 12'h40); push("mid_hex4", 4, 12'h79);
    check();
    frame();
    push("mid_sof_ds", 6, 12'h001); push("mid_sof_cu", 7, 12'h1);
    push("mid_sof_hex4", 4, 12'h79); push("mid_sof_hex0", 0, 12'h40);
    check();
    tick();
    push("mid_lat_hex4", 4, 12'h78); push("mid_lat_hex0", 0, 12'h79);
    check();
    score = 12'h001; level = 4'd2;
    @(negedge clk) begin startOfFrame = 1'b1; newLevelPulse = 1'b1; end
    @(negedge clk) begin startOfFrame = 1'b0; newLevelPulse = 1'b0; end
    tick();
    push("flash_load", 4, 12'h7F);
    check();
    for (int j = 1; j <= 61; j++) begin
      frame(); tick();
      c = (j > 60) ? 0 : 60 - j;
      push("flash_hex4", 4, (c != 0 && ((c / 8) % 2) == 1) ? 12'h7F : 12'h24);
      check();
    end
    level = 4'd12;
    frame(); tick();
    push("lvl_dash", 4, 12'h3F);
    check();
    level = 4'd9; birdsLeft = 4'd12;
    currScreen = 2'd0; frame(); tick();
    push("scr0_hex5", 5, 12'h3F); push("scr0_hex4", 4, 12'h7F); push("scr0_hex3", 3, 12'h7F);
    check();
    currScreen = 2'd1; frame(); tick();
    push("scr1_hex5", 5, 12'h0C); push("scr1_hex3", 3, 12'h3F); push("scr1_hex4", 4, 12'h10);
    check();
    currScreen = 2'd2; frame(); tick();
    push("scr2_hex5", 5, 12'h47); push("scr2_hex3", 3, 12'h7F);
    check();
    currScreen = 2'd3; frame(); tick();
    push("scr3_hex5", 5, 12'h41);
    check();
    score = 12'h999; currScreen = 2'd1;
    repeat (5) frame();
    push("pre_rst_ds", 6, 12'h006); push("pre_rst_cu", 7, 12'h1);
    check();
    @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    push("arst_ds", 6, 12'h000); push("arst_cu", 7, 12'h0); push("arst_hex0", 0, 12'h40);
    push("arst_hex1", 1, 12'h7F); push("arst_hex4", 4, 12'h7F); push("arst_hex5", 5, 12'h3F);
    check();
    @(negedge clk) resetN = 1'b1;
    frame();
    push("post_rst_ds", 6, 12'h001); push("post_rst_cu", 7, 12'h1);
    check();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
